eigen_deflation_sequencer: RTL and testbench

Control FSM that time-multiplexes a single `find_eigen` power-iteration engine across all SIZE_N eigenpairs, replacing the unrolled SIZE_N-instance chain. It accepts a covariance matrix from upstream and issues one engine run per eigenpair. Between runs it ping-pongs two matrix buffers so each run reads the previous run's deflated matrix. It also writes eigenpair index strobes to the result store and reports completion or timeout to the ICA/whitening stage. The block is control-only; matrix and eigen data live in external buffers steered by its outputs.

---
 rtl/eigen_deflation_sequencer.sv | 136 +++++++++++++
 tb/tb_eigen_deflation_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eigen_deflation_sequencer.sv
// Control sequencer that time-multiplexes one find_eigen power-iteration
// engine across SIZE_N eigenpairs. Between runs it ping-pongs two matrix
// buffers, strobes the eigenpair store and reports done/timeout.
// All outputs are registered. Each pulse is one cycle wide.
module eigen_deflation_sequencer #(
  parameter int SIZE_N  = 8,
  parameter int TIMEOUT = 4096,
  parameter int IDX_W   = (SIZE_N > 1) ? $clog2(SIZE_N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [31:0]      scale,
  input  logic             abort,
  output logic             ack,
  output logic             load_cov,
  output logic             eng_start,
  output logic [31:0]      eng_scale,
  input  logic             eng_valid,
  output logic             buf_sel,
  output logic             eig_we,
  output logic [IDX_W-1:0] eig_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(SIZE_N - 1);
  localparam logic [CW-1:0]    CNT_LIM = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_STORE,
    S_SWAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;

  // State, wait counter and all registered (Moore) outputs. The output
  // registers are loaded on the edge that enters each state, so every
  // output reflects the state it is presented in. eig_idx doubles as the
  // eigenpair counter k.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      ack         <= 1'b0;
      load_cov    <= 1'b0;
      eng_start   <= 1'b0;
      eng_scale   <= '0;
      buf_sel     <= 1'b0;
      eig_we      <= 1'b0;
      eig_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack       <= 1'b0;
      load_cov  <= 1'b0;
      eng_start <= 1'b0;
      eig_we    <= 1'b0;
      done      <= 1'b0;
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req && !abort) begin
              state       <= S_LOAD;
              busy        <= 1'b1;
              ack         <= 1'b1;
              load_cov    <= 1'b1;
              eng_scale   <= scale;
              eig_idx     <= '0;
              buf_sel     <= 1'b0;
              timeout_err <= 1'b0;
            end
          end
          S_LOAD: begin
            state     <= S_START;
            eng_start <= 1'b1;
            wait_cnt  <= '0;
          end
          S_START: begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
          S_WAIT: begin
            if (!(&wait_cnt)) wait_cnt <= wait_cnt + CW'(1);
            // eng_valid on the limit cycle takes priority over the timeout
            if (eng_valid) begin
              state  <= S_STORE;
              eig_we <= 1'b1;
            end else if (wait_cnt == CNT_LIM) begin
              state       <= S_ERR;
              done        <= 1'b1;
              timeout_err <= 1'b1;
            end
          end
          S_STORE: begin
            if (eig_idx == K_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SWAP;
            end
          end
          S_SWAP: begin
            state     <= S_START;
            eng_start <= 1'b1;
            wait_cnt  <= '0;
            buf_sel   <= ~buf_sel;
            if (eig_idx != K_LAST) eig_idx <= eig_idx + IDX_W'(1);
          end
          S_DONE, S_ERR: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eigen_deflation_sequencer.sv
// Directed bench for eigen_deflation_sequencer with a fixed-latency engine
// model. Inputs are driven and outputs sampled on the falling clock edge.
module tb_eigen_deflation_sequencer;

  localparam int N  = 8;
  localparam int TO = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [31:0]   scale = '0;
  logic          abort = 1'b0;
  logic          eng_valid = 1'b0;
  logic          ack, load_cov, eng_start, buf_sel, eig_we, busy, done, timeout_err;
  logic [31:0]   eng_scale;
  logic [IW-1:0] eig_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cd = 0;
  int lat = 5;
  int dead_k = -1;
  bit silent = 1'b0;

  eigen_deflation_sequencer #(.SIZE_N(N), .TIMEOUT(TO), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .scale(scale), .abort(abort),
    .ack(ack), .load_cov(load_cov), .eng_start(eng_start), .eng_scale(eng_scale),
    .eng_valid(eng_valid), .buf_sel(buf_sel), .eig_we(eig_we), .eig_idx(eig_idx),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; the engine model answers lat cycles after eng_start
  // unless the run index matches dead_k.
  task automatic step();
    @(negedge clk);
    cyc++;
    eng_valid = 1'b0;
    if (eng_start === 1'b1) begin
      cd = lat;
      silent = (int'(eig_idx) == dead_k);
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && !silent) eng_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; abort = 1'b0;
    step(); step();
    rst = 1'b0; cd = 0; silent = 1'b0; dead_k = -1; lat = 5;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ack, load_cov, eng_start, eig_we, busy, done, timeout_err, buf_sel, eig_idx, eng_scale} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b ld=%b st=%b we=%b busy=%b done=%b terr=%b bs=%b idx=%0d scale=%h exp all zero",
               ack, load_cov, eng_start, eig_we, busy, done, timeout_err, buf_sel, eig_idx, eng_scale);
    end
  endtask

  task automatic test_normal();
    bit ea, es, ew, ed, eb;
    do_reset();
    step(); req = 1'b1; scale = 32'h0001_8000;
    for (int r = 1; r <= 70; r++) begin
      step();
      if (r == 1) req = 1'b0;
      ea = (r == 1);
      es = (r >= 2) && ((r - 2) % 8 == 0) && ((r - 2) / 8 < 8);
      ew = (r >= 8) && ((r - 8) % 8 == 0) && ((r - 8) / 8 < 8);
      ed = (r == 65);
      eb = (r >= 1) && (r <= 65);
      checks++;
      if ({ack, load_cov, eng_start, eig_we, done, busy} !== {ea, ea, es, ew, ed, eb}) begin
        errors++;
        $display("FAIL normal_pulses r=%0d got ack,ld,st,we,done,busy=%b%b%b%b%b%b exp %b%b%b%b%b%b",
                 r, ack, load_cov, eng_start, eig_we, done, busy, ea, ea, es, ew, ed, eb);
      end
      if (es) begin
        checks++;
        if (buf_sel !== 1'(((r - 2) / 8) % 2) || eig_idx !== IW'((r - 2) / 8)) begin
          errors++;
          $display("FAIL normal_start_idx r=%0d got bs=%b idx=%0d exp bs=%0d idx=%0d",
                   r, buf_sel, eig_idx, ((r - 2) / 8) % 2, (r - 2) / 8);
        end
      end
      if (ew) begin
        checks++;
        if (eig_idx !== IW'((r - 8) / 8)) begin
          errors++;
          $display("FAIL normal_we_idx r=%0d got %0d exp %0d", r, eig_idx, (r - 8) / 8);
        end
      end
      if (r == 1) begin
        checks++;
        if (eng_scale !== 32'h0001_8000 || timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL normal_scale got %h terr=%b exp 00018000 terr=0", eng_scale, timeout_err);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit es, ew, ed, eb, et;
    do_reset();
    dead_k = 3;
    step(); req = 1'b1; scale = 32'h0000_4000;
    for (int r = 1; r <= 50; r++) begin
      step();
      if (r == 1) req = 1'b0;
      es = (r >= 2) && ((r - 2) % 8 == 0) && ((r - 2) / 8 < 4);
      ew = (r >= 8) && ((r - 8) % 8 == 0) && ((r - 8) / 8 < 3);
      ed = (r == 43);
      eb = (r >= 1) && (r <= 43);
      et = (r >= 43);
      checks++;
      if ({eng_start, eig_we, done, busy, timeout_err} !== {es, ew, ed, eb, et}) begin
        errors++;
        $display("FAIL timeout_seq r=%0d got st,we,done,busy,terr=%b%b%b%b%b exp %b%b%b%b%b",
                 r, eng_start, eig_we, done, busy, timeout_err, es, ew, ed, eb, et);
      end
      if (r == 43) begin
        checks++;
        if (eig_idx !== 3'd3) begin
          errors++;
          $display("FAIL timeout_idx got %0d exp 3", eig_idx);
        end
      end
    end
    checks++;
    if (timeout_err !== 1'b1 || eig_idx !== 3'd3) begin
      errors++;
      $display("FAIL timeout_sticky got terr=%b idx=%0d exp terr=1 idx=3", timeout_err, eig_idx);
    end
    dead_k = -1;
    req = 1'b1;
    step(); req = 1'b0;
    checks++;
    if (ack !== 1'b1 || timeout_err !== 1'b0 || eig_idx !== 3'd0) begin
      errors++;
      $display("FAIL timeout_clear got ack=%b terr=%b idx=%0d exp ack=1 terr=0 idx=0", ack, timeout_err, eig_idx);
    end
    abort = 1'b1;
    step(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort_load got busy=%b st=%b exp 0 0", busy, eng_start);
    end
  endtask

  task automatic test_limit();
    do_reset();
    lat = TO;
    step(); req = 1'b1;
    for (int r = 1; r <= 22; r++) begin
      step();
      if (r == 1) req = 1'b0;
      if (r == 19 || r == 20) eng_valid = 1'b1;
      if (r >= 17 && r <= 22) begin
        checks++;
        if (timeout_err !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL limit_noerr r=%0d got terr=%b done=%b exp 0 0", r, timeout_err, done);
        end
      end
      if (r == 19) begin
        checks++;
        if (eig_we !== 1'b1 || eig_idx !== 3'd0) begin
          errors++;
          $display("FAIL limit_store got we=%b idx=%0d exp we=1 idx=0", eig_we, eig_idx);
        end
      end
      if (r == 20 || r == 22) begin
        checks++;
        if (eig_we !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL limit_spurious r=%0d got we=%b st=%b busy=%b exp 0 0 1", r, eig_we, eng_start, busy);
        end
      end
      if (r == 21) begin
        checks++;
        if (eng_start !== 1'b1 || eig_we !== 1'b0 || eig_idx !== 3'd1 || buf_sel !== 1'b1) begin
          errors++;
          $display("FAIL limit_restart got st=%b we=%b idx=%0d bs=%b exp 1 0 1 1", eng_start, eig_we, eig_idx, buf_sel);
        end
      end
    end
    abort = 1'b1;
    step(); abort = 1'b0;
    eng_valid = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || eig_we !== 1'b0) begin
      errors++;
      $display("FAIL limit_idle_valid got busy=%b ack=%b we=%b exp 0 0 0", busy, ack, eig_we);
    end
  endtask

  task automatic test_abort();
    bit es, ew, eb;
    do_reset();
    step(); req = 1'b1; scale = 32'h0003_0000;
    for (int r = 1; r <= 40; r++) begin
      step();
      if (r == 1) req = 1'b0;
      if (r == 20) abort = 1'b1;
      if (r == 21) abort = 1'b0;
      es = (r == 2) || (r == 10) || (r == 18);
      ew = (r == 8) || (r == 16);
      eb = (r >= 1) && (r <= 20);
      checks++;
      if ({eng_start, eig_we, done, busy} !== {es, ew, 1'b0, eb}) begin
        errors++;
        $display("FAIL abort_seq r=%0d got st,we,done,busy=%b%b%b%b exp %b%b0%b",
                 r, eng_start, eig_we, done, busy, es, ew, eb);
      end
      if (r == 21) begin
        checks++;
        if (eig_idx !== 3'd2 || buf_sel !== 1'b0 || eng_scale !== 32'h0003_0000) begin
          errors++;
          $display("FAIL abort_hold got idx=%0d bs=%b scale=%h exp 2 0 00030000", eig_idx, buf_sel, eng_scale);
        end
      end
    end
    step(); req = 1'b1;
    for (int r = 1; r <= 12; r++) begin
      step();
      if (r == 1) req = 1'b0;
      if (r == 7) abort = 1'b1;
      if (r == 8) abort = 1'b0;
      if (r >= 8) begin
        checks++;
        if (eig_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || eng_start !== 1'b0) begin
          errors++;
          $display("FAIL abort_vs_valid r=%0d got we=%b busy=%b done=%b st=%b exp 0 0 0 0",
                   r, eig_we, busy, done, eng_start);
        end
      end
    end
    req = 1'b1; abort = 1'b1;
    step();
    req = 1'b0; abort = 1'b0;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_req_idle got ack=%b busy=%b exp 0 0", ack, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); req = 1'b1; scale = 32'h0007_0000;
    for (int r = 1; r <= 49; r++) begin
      step();
      if (r == 1) req = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || eig_idx !== 3'd5 || eig_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre got busy=%b idx=%0d we=%b exp 1 5 0", busy, eig_idx, eig_we);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ack, load_cov, eng_start, eig_we, busy, done, timeout_err, buf_sel, eig_idx, eng_scale} !== '0) begin
      errors++;
      $display("FAIL rstmid_zero got busy=%b bs=%b idx=%0d scale=%h exp all zero", busy, buf_sel, eig_idx, eng_scale);
    end
    cd = 0;
    step(); req = 1'b1;
    step(); req = 1'b0;
    checks++;
    if (ack !== 1'b1 || eig_idx !== 3'd0 || buf_sel !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_reload got ack=%b idx=%0d bs=%b exp 1 0 0", ack, eig_idx, buf_sel);
    end
    step();
    checks++;
    if (eng_start !== 1'b1 || eig_idx !== 3'd0 || buf_sel !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_start got st=%b idx=%0d bs=%b exp 1 0 0", eng_start, eig_idx, buf_sel);
    end
    abort = 1'b1;
    step(); abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(); req = 1'b1; scale = 32'h0001_0000;
    for (int r = 1; r <= 68; r++) begin
      step();
      if (r == 10) scale = 32'h0002_0000;
      if (r == 1 || r == 65 || r == 66) begin
        checks++;
        if (eng_scale !== 32'h0001_0000) begin
          errors++;
          $display("FAIL b2b_scale_a r=%0d got %h exp 00010000", r, eng_scale);
        end
      end
      if (r == 65) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done got %b exp 1", done);
        end
      end
      if (r == 66) begin
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle got busy=%b ack=%b exp 0 0", busy, ack);
        end
      end
      if (r == 67) begin
        checks++;
        if (ack !== 1'b1 || load_cov !== 1'b1 || busy !== 1'b1 || eng_scale !== 32'h0002_0000) begin
          errors++;
          $display("FAIL b2b_second_load got ack=%b ld=%b busy=%b scale=%h exp 1 1 1 00020000",
                   ack, load_cov, busy, eng_scale);
        end
      end
      if (r == 68) begin
        checks++;
        if (eng_start !== 1'b1 || buf_sel !== 1'b0 || eig_idx !== 3'd0) begin
          errors++;
          $display("FAIL b2b_second_start got st=%b bs=%b idx=%0d exp 1 0 0", eng_start, buf_sel, eig_idx);
        end
      end
    end
    req = 1'b0; abort = 1'b1;
    step(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_reset();
    test_limit();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
